// File: rtl/memorybank_pkg.sv
// Shared definitions for the 64-byte node/cluster-head memory bank and its
// read-side initiator: geometry, reader FSM states, word step and the
// transfer-length clamp.
package memorybank_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned MEM_DEPTH  = 64;
  localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH);
  localparam int unsigned MAX_WORDS  = MEM_DEPTH / 2;
  localparam int unsigned WORD_STEP  = 2;
  localparam int unsigned BYTE_W     = WORD_WIDTH / 2;

  // Clears bit 0 so every word starts on an even byte.
  localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Transfer length limited to one full pass over the bank.
  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] cnt);
    return (cnt > ADDR_W'(MAX_WORDS)) ? ADDR_W'(MAX_WORDS) : cnt;
  endfunction

endpackage

// File: rtl/memorybank.sv
// 64-byte memory bank. One byte-wide write port owned by the bank's writing
// client and a combinational 16-bit read port returning {mem[i], mem[i+1]},
// with i+1 wrapping modulo the bank depth.
// Ports: clk; wr_en/wr_idx/wr_data byte write; rd_idx in; rd_data out (comb).
module memorybank
  import memorybank_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_idx,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     rd_idx,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [BYTE_W-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_W-1:0] rd_idx_hi;

  // Byte write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Odd byte index wraps naturally in ADDR_W bits (63 -> 0).
  assign rd_idx_hi = rd_idx + ADDR_W'(1);
  assign rd_data   = {mem_q[rd_idx], mem_q[rd_idx_hi]};

endmodule

// File: rtl/memorybank_reader.sv
// Read-side initiator for the memory bank. On start it walks word_cnt words
// (clamped to MAX_WORDS) from an even base index, fetching each word from the
// bank's combinational read port and streaming it out over valid/ready with a
// last flag. It never writes the bank.
// Ports: clk, rst (sync, active-high); start/base_idx/word_cnt request;
// busy/done status; mem_req/mem_index/mem_rdata bank side;
// tx_data/tx_valid/tx_ready/tx_last stream side.
module memorybank_reader
  import memorybank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_idx,
  input  logic [ADDR_W-1:0]     word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_index,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last
);

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]     mem_index_q, mem_index_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_W-1:0]     clamped_cnt;

  assign clamped_cnt = clamp_count(word_cnt);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_idx & EVEN_MASK;
          rem_d   = clamped_cnt;
          state_d = (clamped_cnt == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
        tx_last_d  = (rem_q == ADDR_W'(1));
        state_d    = SEND;
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (rem_q > ADDR_W'(1)) begin
            // mem_index already points at the next word (prefetch).
            tx_data_d = mem_rdata;
            ptr_d     = ptr_q + ADDR_W'(WORD_STEP);
            rem_d     = rem_q - ADDR_W'(1);
            tx_last_d = (rem_q == ADDR_W'(2));
          end else begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Status and bank index are registered from the next state so they line
    // up with the state they describe; SEND looks one word ahead.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_index_d = (state_d == SEND) ? (ptr_d + ADDR_W'(WORD_STEP)) : ptr_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      mem_index_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      mem_index_q <= mem_index_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign mem_req   = busy_q;
  assign done      = done_q;
  assign mem_index = mem_index_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;

endmodule
